// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit -- iterative RV32M multiplier (MUL / MULH / MULHSU / MULHU)
//
// Computes the unsigned product of the operand magnitudes with a radix-2
// shift-add loop, one multiplier bit per clock. A final cycle negates the
// 64-bit product if needed and selects the low or high word. The pipeline
// stalls EX on busy and picks up the result on the done pulse.
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   operation request, sampled only while idle
//   flush     in   synchronous abort; takes priority over start
//   num1      in   multiplicand (rs1), sampled with start
//   num2      in   multiplier (rs2), sampled with start
//   mode_sel  in   0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
//   busy      out  operation in flight
//   done      out  one-cycle pulse; mul_dout valid from this cycle
//   mul_dout  out  result word, held until the next completed operation
//
// Configuration
//   MUL_ZERO_SKIP_EN  when defined, a zero operand bypasses the shift-add
//                     loop and the result is produced one edge after start.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | shift-add, one multiplier bit per edge, LSB first
// FIX   | apply sign, select word, pulse done
// -----------------------------------------------------------------------------
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [1:0]       mode_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mul_dout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic               a_signed, b_signed, start_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  // MULH treats both operands as signed, MULHSU only rs1.
  assign a_signed  = (mode_sel == 2'd1) || (mode_sel == 2'd2);
  assign b_signed  = (mode_sel == 2'd1);
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign a_mag     = (a_signed && num1[WIDTH-1]) ? -num1 : num1;
  assign b_mag     = (b_signed && num2[WIDTH-1]) ? -num2 : num2;
  assign start_neg = (a_signed && num1[WIDTH-1]) ^ (b_signed && num2[WIDTH-1]);
  assign prod      = neg_q ? -acc_q : acc_q;

`ifdef MUL_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (num1 == '0) || (num2 == '0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
`ifdef MUL_ZERO_SKIP_EN
          state_d = zero_op ? S_FIX : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
        S_CALC: if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        S_FIX:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = done_q;
    mul_dout = dout_q;
  end

  // Datapath next values
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start && !flush) begin
        mode_d   = mode_sel;
        mcand_d  = {{WIDTH{1'b0}}, a_mag};
        mplier_d = b_mag;
        neg_d    = start_neg;
        acc_d    = '0;
        cnt_d    = '0;
      end
      S_CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      S_FIX: if (!flush) begin
        dout_d = (mode_q == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] num1, num2;
  logic [1:0]  mode_sel;
  logic        busy, done;
  logic [31:0] mul_dout;

  int checks   = 0;
  int failures = 0;

  mul_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .num1     (num1),
    .num2     (num2),
    .mode_sel (mode_sel),
    .busy     (busy),
    .done     (done),
    .mul_dout (mul_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Reference: full 64-bit product from sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(logic [1:0] m, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (m == 2'd1 || m == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (m == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (m == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(logic [31:0] a, logic [31:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives start for one edge (E0); returns at the falling edge after E0.
  task automatic drive_start(bit sync, logic [1:0] m, logic [31:0] a, logic [31:0] b);
    if (sync) @(negedge clk);
    start = 1'b1; mode_sel = m; num1 = a; num2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after E0 until done; optionally pokes a start while busy.
  task automatic wait_done(int poke_at, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == poke_at) begin
        start = 1'b1; mode_sel = 2'd3; num1 = 32'd9; num2 = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_op(string name, logic [1:0] m, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, bit chk_busy);
    int lat, bcnt;
    drive_start(1'b1, m, a, b);
    wait_done(-1, lat, bcnt);
    check({name, " latency"}, lat, exp_lat(a, b));
    check({name, " result"}, mul_dout, exp);
    check({name, " busy at done"}, busy, 1'b0);
    if (chk_busy) check({name, " busy cycles"}, bcnt, exp_lat(a, b));
  endtask

  initial begin
    int lat, bcnt, nd;
    logic [1:0]  m;
    logic [31:0] a, b;

    vecs[0] = '{2'd0, 32'd7,        32'd6,        32'h0000002A};
    vecs[1] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[3] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[4] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[6] = '{2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[7] = '{2'd3, 32'h80000000, 32'h00000002, 32'h00000001};
    vecs[8] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9] = '{2'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    num1 = '0; num2 = '0; mode_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dout", mul_dout, 32'd0);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b,
                             vecs[i].exp, 1'b1);

    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'h80000000;
      run_op($sformatf("rand%0d", i), m, a, b, ref_mul(m, a, b), 1'b0);
    end

    // Flush at E10 of MUL 3x5 after a 7x6 result.
    run_op("pre_flush", 2'd0, 32'd7, 32'd6, 32'h2A, 1'b0);
    drive_start(1'b1, 2'd0, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", busy, 1'b0);
    check("flush done", done, 1'b0);
    check("flush dout", mul_dout, 32'h2A);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("flush no done", nd, 0);
    check("flush dout held", mul_dout, 32'h2A);

    // Start while busy ignored, then back-to-back start in the done cycle.
    drive_start(1'b1, 2'd0, 32'd7, 32'd6);
    wait_done(5, lat, bcnt);
    check("ignore latency", lat, 33);
    check("ignore result", mul_dout, 32'h2A);
    drive_start(1'b0, 2'd0, 32'd3, 32'd5);
    wait_done(-1, lat, bcnt);
    check("b2b latency", lat, 33);
    check("b2b result", mul_dout, 32'd15);

    run_op("zero", 2'd0, 32'd0, 32'h1234, 32'd0, 1'b1);
    run_op("post_zero", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);

    // Reset at E20.
    drive_start(1'b1, 2'd1, 32'h80000000, 32'h80000000);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst dout", mul_dout, 32'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("rst no done", nd, 0);
    run_op("post_rst", 2'd0, 32'd7, 32'd6, 32'h2A, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
